game_timer_ctrl: RTL and testbench

Run-state controller for the in-game elapsed-time BCD counter. It sequences the counter through idle, run, pause and game-over states, and generates the one-cycle count strobe from the system clock through a prescaler. It issues the counter clear on each new game and ends the game on collision or on reaching a BCD time limit. It sits between the button and collision logic and the 16-bit BCD elapsed-time counter, and also drives a blink enable for the time display.

---
 rtl/game_timer_ctrl_if.sv | 25 ++
 rtl/game_timer_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_game_timer_ctrl.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/game_timer_ctrl_if.sv
// game_timer_ctrl_if: signal bundle between the run-state controller and its
// neighbours (buttons, collision logic, BCD elapsed-time counter, display).
//   master : controller side (drives tick/cnt_clr/state/timeout/blink)
//   slave  : environment side (drives start/pause/gameover/cnt)
interface game_timer_ctrl_if;
  logic        start;     // start/restart button, synchronised level
  logic        pause;     // pause/resume button, synchronised level
  logic        gameover;  // collision level
  logic [15:0] cnt;       // current BCD elapsed time
  logic        tick;      // one-cycle count strobe
  logic        cnt_clr;   // one-cycle synchronous counter clear
  logic [1:0]  state;     // IDLE=00 RUN=01 PAUSE=10 OVER=11
  logic        timeout;   // sticky: game ended on the time limit
  logic        blink;     // display enable

  modport master (
    input  start, pause, gameover, cnt,
    output tick, cnt_clr, state, timeout, blink
  );

  modport slave (
    output start, pause, gameover, cnt,
    input  tick, cnt_clr, state, timeout, blink
  );
endinterface

// File: rtl/game_timer_ctrl.sv
// game_timer_ctrl: run-state controller for the in-game BCD elapsed-time counter.
// Latency: all outputs registered; gameover -> OVER in 1 cycle, time limit -> OVER in 2.
// Backpressure: none; level/edge inputs are sampled every cycle, strobes are fire-and-forget.
//
// Ports:
//   clk    - system clock, rising edge
//   reset  - synchronous active-high reset
//   bus    - game_timer_ctrl_if.master: start/pause/gameover/cnt in,
//            tick/cnt_clr/state/timeout/blink out
// Parameters:
//   TICK_DIV   - clk cycles per count strobe (>= 2)
//   BLINK_DIV  - clk cycles per blink half-period (>= 2)
//   TIME_LIMIT - BCD value of cnt that ends the game
// Build option:
//   GAME_TIMER_TIMEOUT_EN - when defined, compiles in the time-limit compare and
//   the sticky timeout flag; otherwise timeout is tied low and RUN only leaves on
//   gameover or pause.
module game_timer_ctrl #(
  parameter int          TICK_DIV   = 100_000_000,
  parameter int          BLINK_DIV  = 25_000_000,
  parameter logic [15:0] TIME_LIMIT = 16'h0959
) (
  input  logic              clk,
  input  logic              reset,
  game_timer_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    OVER  = 2'b11
  } state_t;

  localparam int PW = (TICK_DIV  > 1) ? $clog2(TICK_DIV)  : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [PW-1:0] PRE_MAX  = PW'(TICK_DIV - 1);
  // tick is registered, so it is scheduled one count early to appear in the
  // cycle where the prescaler holds TICK_DIV-1
  localparam logic [PW-1:0] PRE_TICK = PW'(TICK_DIV - 2);
  localparam logic [BW-1:0] BL_MAX   = BW'(BLINK_DIV - 1);

  state_t        state_q;
  state_t        next_state;
  logic          start_q;
  logic          pause_q;
  logic          start_rise;
  logic          pause_rise;
  logic          entry;      // new game: IDLE/OVER -> RUN on start
  logic          to_set;     // leaving RUN because the time limit was hit
  logic          hit;        // registered time-limit match
  logic [PW-1:0] presc;
  logic [BW-1:0] bcnt;
  logic          tick_q;
  logic          clr_q;
  logic          blink_q;

  // Edge registers reset to 1 so a button held through reset never fires.
  assign start_rise = bus.start & ~start_q;
  assign pause_rise = bus.pause & ~pause_q;

  // ---------------------------------------------------------------------------
  // Next-state logic. Priority: gameover > time limit > pause > start.
  // ---------------------------------------------------------------------------
  always_comb begin
    next_state = state_q;
    entry      = 1'b0;
    to_set     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_rise) begin
          next_state = RUN;
          entry      = 1'b1;
        end
      end
      RUN: begin
        if (bus.gameover) begin
          next_state = OVER;
        end else if (hit) begin
          next_state = OVER;
          to_set     = 1'b1;
        end else if (pause_rise) begin
          next_state = PAUSE;
        end
      end
      PAUSE: begin
        if (bus.gameover) begin
          next_state = OVER;
        end else if (pause_rise || start_rise) begin
          next_state = RUN;
        end
      end
      OVER: begin
        // A still-asserted gameover is only seen once back in RUN.
        if (start_rise) begin
          next_state = RUN;
          entry      = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register, edge registers, strobes, prescaler and blink.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      start_q <= 1'b1;
      pause_q <= 1'b1;
      tick_q  <= 1'b0;
      clr_q   <= 1'b0;
      presc   <= '0;
      bcnt    <= '0;
      blink_q <= 1'b0;
    end else begin
      state_q <= next_state;
      start_q <= bus.start;
      pause_q <= bus.pause;
      clr_q   <= entry;

      // A tick due in a cycle that is no longer RUN is dropped.
      tick_q  <= (state_q == RUN) && (next_state == RUN) && (presc == PRE_TICK);

      // Prescaler advances only in RUN and holds elsewhere, so a pause keeps
      // the partial second.
      if (entry) begin
        presc <= '0;
      end else if (state_q == RUN) begin
        presc <= (presc == PRE_MAX) ? '0 : presc + 1'b1;
      end

      // Every state change restarts the blink phase; only IDLE starts dark.
      if (next_state != state_q) begin
        bcnt    <= '0;
        blink_q <= (next_state != IDLE);
      end else if (state_q == PAUSE || state_q == OVER) begin
        if (bcnt == BL_MAX) begin
          bcnt    <= '0;
          blink_q <= ~blink_q;
        end else begin
          bcnt <= bcnt + 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Time-limit compare and sticky timeout flag.
  // ---------------------------------------------------------------------------
`ifdef GAME_TIMER_TIMEOUT_EN
  logic hit_q;
  logic timeout_q;

  // The clear cycle is excluded: cnt still shows the previous game's value
  // until the counter applies cnt_clr at the end of that cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_q     <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      hit_q <= (state_q == RUN) && !clr_q && (bus.cnt == TIME_LIMIT);
      if (entry) begin
        timeout_q <= 1'b0;
      end else if (to_set) begin
        timeout_q <= 1'b1;
      end
    end
  end

  assign hit         = hit_q;
  assign bus.timeout = timeout_q;
`else
  wire unused_cfg = ^{TIME_LIMIT, bus.cnt, to_set};

  assign hit         = 1'b0;
  assign bus.timeout = 1'b0;
`endif

  assign bus.state   = state_q;
  assign bus.tick    = tick_q;
  assign bus.cnt_clr = clr_q;
  assign bus.blink   = blink_q;

endmodule

// File: tb/tb_game_timer_ctrl.sv
// tb_game_timer_ctrl: self-checking bench for game_timer_ctrl.
// Vector table for the first game, hand-written sequences for timeout,
// collision, restart, pause/resume and reset corners; tick arrival cycles are
// checked against a queue of expected cycle numbers.
module tb_game_timer_ctrl;

  localparam int          TD = 4;
  localparam int          BD = 3;
  localparam logic [15:0] TL = 16'h0003;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  game_timer_ctrl_if bus();

  game_timer_ctrl #(
    .TICK_DIV  (TD),
    .BLINK_DIV (BD),
    .TIME_LIMIT(TL)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.master)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  int cyc    = 0;
  int exp_ticks[$];

  typedef struct {
    logic       start;
    logic       pause;
    logic       gameover;
    logic [1:0] e_state;
    logic       e_tick;
    logic       e_clr;
    logic       e_to;
    logic       e_blink;
  } vec_t;

  vec_t tbl[14];

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int d = 0; d < 4; d++) begin
      if (carry) begin
        if (r[d*4 +: 4] == 4'd9) begin
          r[d*4 +: 4] = 4'd0;
        end else begin
          r[d*4 +: 4] = r[d*4 +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // BCD elapsed-time counter model driving cnt.
  always @(posedge clk) begin
    if (reset || bus.cnt_clr) bus.cnt <= 16'h0000;
    else if (bus.tick)        bus.cnt <= bcd_inc(bus.cnt);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic chk_out(input string name, input logic [1:0] st, input logic tk,
                         input logic clr, input logic to, input logic bl);
    chk({name, ".state"},   bus.state,   st);
    chk({name, ".tick"},    bus.tick,    tk);
    chk({name, ".cnt_clr"}, bus.cnt_clr, clr);
    chk({name, ".timeout"}, bus.timeout, to);
    chk({name, ".blink"},   bus.blink,   bl);
  endtask

  // One clock; outputs are observed 1 time unit after the rising edge.
  task automatic step();
    int e;
    @(posedge clk);
    #1;
    cyc++;
    if (bus.tick) begin
      chk("tick_clr_excl", bus.cnt_clr, 1'b0);
      chk("tick_in_run", bus.state, 2'b01);
      if (exp_ticks.size() > 0) begin
        e = exp_ticks.pop_front();
        chk("tick_cycle", cyc, e);
      end else begin
        chk("tick_unexpected", bus.tick, 1'b0);
      end
    end else if (exp_ticks.size() > 0 && exp_ticks[0] <= cyc) begin
      e = exp_ticks.pop_front();
      chk("tick_missing", bus.tick, 1'b1);
    end
  endtask

  initial begin
    // First game: cycle 1 is the clear cycle, ticks on RUN cycles 4, 8, 12.
    for (int i = 0; i < 14; i++) begin
      tbl[i] = '{start: (i == 0), pause: 1'b0, gameover: 1'b0, e_state: 2'b01,
                 e_tick: (i == 3 || i == 7 || i == 11), e_clr: (i == 0),
                 e_to: 1'b0, e_blink: 1'b1};
    end

    bus.start    = 1'b0;
    bus.pause    = 1'b0;
    bus.gameover = 1'b0;

    step();
    step();
    chk_out("reset", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    step();
    chk_out("idle", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

    exp_ticks.push_back(cyc + 4);
    exp_ticks.push_back(cyc + 8);
    exp_ticks.push_back(cyc + 12);
    for (int i = 0; i < 14; i++) begin
      bus.start    = tbl[i].start;
      bus.pause    = tbl[i].pause;
      bus.gameover = tbl[i].gameover;
      step();
      chk_out($sformatf("vec%0d", i), tbl[i].e_state, tbl[i].e_tick,
              tbl[i].e_clr, tbl[i].e_to, tbl[i].e_blink);
    end
    chk("cnt_at_limit", bus.cnt, TL);

`ifdef GAME_TIMER_TIMEOUT_EN
    // Limit seen in cycle 13, registered in 14, OVER with timeout in 15.
    step();
    chk_out("timeout_hit", 2'b11, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int k = 1; k <= 6; k++) begin
      step();
      chk($sformatf("over%0d.state", k), bus.state, 2'b11);
      chk($sformatf("over%0d.timeout", k), bus.timeout, 1'b1);
      chk($sformatf("over%0d.blink", k), bus.blink, ((k / 3) % 2) == 0);
    end
    step();
    bus.start = 1'b1;
    step();
    chk_out("restart_over", 2'b01, 1'b0, 1'b1, 1'b0, 1'b1);
    bus.start = 1'b0;
`else
    exp_ticks.push_back(cyc + 2);
    exp_ticks.push_back(cyc + 6);
    for (int k = 0; k < 7; k++) begin
      step();
      chk($sformatf("nolimit%0d.state", k), bus.state, 2'b01);
      chk($sformatf("nolimit%0d.timeout", k), bus.timeout, 1'b0);
    end
    chk("cnt_past_limit", bus.cnt, 16'h0005);
    step();
    bus.start = 1'b1;
    step();
    chk("start_in_run.state", bus.state, 2'b01);
    chk("start_in_run.cnt_clr", bus.cnt_clr, 1'b0);
    bus.start = 1'b0;
`endif

    // Collision beats pause in the same RUN cycle.
    bus.pause    = 1'b1;
    bus.gameover = 1'b1;
    step();
    chk_out("collision", 2'b11, 1'b0, 1'b0, 1'b0, 1'b1);

    // Restart while gameover is still high: RUN for one cycle, then OVER.
    bus.pause = 1'b0;
    step();
    bus.start = 1'b1;
    step();
    chk_out("restart_go", 2'b01, 1'b0, 1'b1, 1'b0, 1'b1);
    step();
    chk("restart_go_back.state", bus.state, 2'b11);
    chk("restart_go_back.cnt_clr", bus.cnt_clr, 1'b0);

    // Fresh game, pause after two RUN cycles.
    bus.gameover = 1'b0;
    bus.start    = 1'b0;
    step();
    bus.start = 1'b1;
    step();
    chk_out("start2", 2'b01, 1'b0, 1'b1, 1'b0, 1'b1);
    bus.start = 1'b0;
    step();
    chk("run2.state", bus.state, 2'b01);
    bus.pause = 1'b1;
    step();
    chk_out("pause_enter", 2'b10, 1'b0, 1'b0, 1'b0, 1'b1);
    bus.pause = 1'b0;
    for (int k = 2; k <= 10; k++) begin
      step();
      chk($sformatf("pause%0d.state", k), bus.state, 2'b10);
      chk($sformatf("pause%0d.tick", k), bus.tick, 1'b0);
      chk($sformatf("pause%0d.blink", k), bus.blink, (((k - 1) / 3) % 2) == 0);
    end

    // Two prescaler counts remain: first tick on the 2nd RUN cycle after resume.
    bus.pause = 1'b1;
    exp_ticks.push_back(cyc + 2);
    exp_ticks.push_back(cyc + 6);
    step();
    chk_out("resume", 2'b01, 1'b0, 1'b0, 1'b0, 1'b1);
    bus.pause = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      chk($sformatf("resumed%0d.state", k), bus.state, 2'b01);
    end

    // Reset mid-game with start held through it.
    reset     = 1'b1;
    bus.start = 1'b1;
    step();
    chk_out("reset_mid", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    reset = 1'b0;
    step();
    chk_out("held_start0", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    chk_out("held_start1", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

    chk("sb_empty", exp_ticks.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
